sha_padder: RTL and testbench

//  Message pre-processor in front of sha_digester: accepts a byte stream, applies
//  SHA-256 padding (0x80, zero fill, 64-bit big-endian bit length) and emits
//  512-bit blocks as message[16] words with a load/block_ready handshake.

---
 rtl/sha_padder_if.sv | 22 ++
 rtl/sha_padder.sv | 128 ++++++++++++
 tb/tb_sha_padder.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha_padder_if.sv
// SHA padder handshake bundle: byte stream in, padded 512-bit blocks out.
// master drives the byte stream and block_ready; slave is the padder.
interface sha_padder_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic [31:0] message [16];
  logic        load;
  logic        block_ready;
  logic        last_block;

  modport master (
    output in_valid, in_data, in_last, block_ready,
    input  in_ready, message, load, last_block
  );

  modport slave (
    input  in_valid, in_data, in_last, block_ready,
    output in_ready, message, load, last_block
  );
endinterface

// File: rtl/sha_padder.sv
// SHA-256 message padder: packs bytes into 512-bit blocks, appends 0x80,
// zero fill and the 64-bit big-endian bit length, one or two pad blocks.
module sha_padder #(
  parameter int LEN_W = 64
) (
  input logic       clk,
  input logic       rst_n,
  sha_padder_if.slave bus
);

  typedef enum logic [1:0] {
    FILL,
    PAD,
    LEN_ONLY,
    EMIT
  } state_t;

  state_t           state, state_d;
  state_t           nxt, nxt_d;
  logic [5:0]       idx, idx_d;
  logic [LEN_W-1:0] bit_len, len_d;
  logic [511:0]     blk, blk_d;
  logic             load, load_d;
  logic             last, last_d;
  logic [63:0]      len64;
  logic [8:0]       top;
  logic             accept;

  assign bus.in_ready   = rst_n && (state == FILL);
  assign accept         = bus.in_valid && bus.in_ready;
  assign bus.load       = load;
  assign bus.last_block = last;

  for (genvar w = 0; w < 16; w++) begin : g_word
    assign bus.message[w] = blk[511-32*w -: 32];
  end

  // byte idx sits at bits (63-idx)*8+7 down, i.e. {~idx, 3'b111}
  assign top = {~idx, 3'b111};

  always_comb begin
    len64 = '0;
    len64[LEN_W-1:0] = bit_len;
  end

  always_comb begin
    state_d = state;
    nxt_d   = nxt;
    idx_d   = idx;
    len_d   = bit_len;
    blk_d   = blk;
    load_d  = load;
    last_d  = last;
    unique case (state)
      FILL: begin
        if (accept) begin
          blk_d[top -: 8] = bus.in_data;
          idx_d = idx + 6'd1;
          len_d = bit_len + LEN_W'(8);
          if (idx == 6'd63) begin
            state_d = EMIT;
            load_d  = 1'b1;
            last_d  = 1'b0;
            nxt_d   = bus.in_last ? PAD : FILL;
            idx_d   = '0;
          end else if (bus.in_last) begin
            state_d = PAD;
          end
        end
      end
      PAD: begin
        // bytes after idx are already zero: buffer is cleared per block
        blk_d[top -: 8] = 8'h80;
        state_d = EMIT;
        load_d  = 1'b1;
        if (idx < 6'd56) begin
          blk_d[63:0] = len64;
          last_d = 1'b1;
          nxt_d  = FILL;
        end else begin
          last_d = 1'b0;
          nxt_d  = LEN_ONLY;
        end
      end
      LEN_ONLY: begin
        blk_d[63:0] = len64;
        state_d = EMIT;
        load_d  = 1'b1;
        last_d  = 1'b1;
        nxt_d   = FILL;
      end
      EMIT: begin
        if (bus.block_ready) begin
          load_d  = 1'b0;
          last_d  = 1'b0;
          blk_d   = '0;
          state_d = nxt;
          if (last) begin
            len_d = '0;
            idx_d = '0;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FILL;
      nxt     <= FILL;
      idx     <= '0;
      bit_len <= '0;
      blk     <= '0;
      load    <= 1'b0;
      last    <= 1'b0;
    end else begin
      state   <= state_d;
      nxt     <= nxt_d;
      idx     <= idx_d;
      bit_len <= len_d;
      blk     <= blk_d;
      load    <= load_d;
      last    <= last_d;
    end
  end

endmodule

// File: tb/tb_sha_padder.sv
// Bench for sha_padder: directed scenarios plus random back-to-back
// messages checked against a queue-based SHA-256 padding model.
module tb_sha_padder;

  typedef logic [7:0] bq_t [$];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sha_padder_if bus ();

  sha_padder #(.LEN_W(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [511:0] exp_blk [$];
  logic         exp_last [$];
  logic [511:0] cap_blk [$];
  logic         cap_last [$];
  int checks = 0;
  int errors = 0;
  int br_mode = 0;

  function automatic logic [511:0] cur_blk();
    logic [511:0] b;
    b = '0;
    for (int w = 0; w < 16; w++) b[511-32*w -: 32] = bus.message[w];
    return b;
  endfunction

  always @(posedge clk) begin
    if (rst_n && bus.load && bus.block_ready) begin
      cap_blk.push_back(cur_blk());
      cap_last.push_back(bus.last_block);
    end
  end

  task automatic tick();
    if (br_mode == 1) bus.block_ready = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs,
                     input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected progress", tag);
  endtask

  // Reference: standard SHA-256 padding of the whole message, then split
  task automatic expect_msg(input bq_t m);
    bq_t p;
    logic [63:0] bl;
    logic [511:0] b;
    int n;
    p = m;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bl = 64'(m.size()) * 64'd8;
    for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
    n = p.size() / 64;
    for (int k = 0; k < n; k++) begin
      b = '0;
      for (int j = 0; j < 64; j++) b[511-8*j -: 8] = p[64*k+j];
      exp_blk.push_back(b);
      exp_last.push_back(k == n - 1);
    end
  endtask

  task automatic send(input bq_t m, input bit last_on_end, input int gap_max);
    int g;
    int budget;
    bit acc;
    for (int i = 0; i < m.size(); i++) begin
      g = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
      bus.in_valid = 1'b0;
      for (int k = 0; k < g; k++) begin
        bus.in_last = 1'($urandom_range(0, 1));
        bus.in_data = 8'($urandom);
        tick();
      end
      bus.in_valid = 1'b1;
      bus.in_data  = m[i];
      bus.in_last  = last_on_end && (i == m.size() - 1);
      acc = 1'b0;
      budget = 0;
      while (!acc) begin
        acc = bus.in_ready;
        tick();
        budget++;
        if (budget > 2000) begin
          fail_now("accept_timeout");
          bus.in_valid = 1'b0;
          return;
        end
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_blocks(input string tag);
    int budget;
    budget = 0;
    while (cap_blk.size() < exp_blk.size()) begin
      tick();
      budget++;
      if (budget > 5000) begin
        fail_now({tag, "_block_timeout"});
        return;
      end
    end
  endtask

  task automatic drain(input string tag);
    wait_blocks(tag);
    chk({tag, "_count"}, 512'(cap_blk.size()), 512'(exp_blk.size()));
    for (int i = 0; i < exp_blk.size() && i < cap_blk.size(); i++) begin
      chk($sformatf("%s_blk%0d", tag, i), cap_blk[i], exp_blk[i]);
      chk($sformatf("%s_last%0d", tag, i), 512'(cap_last[i]), 512'(exp_last[i]));
    end
    exp_blk.delete();
    exp_last.delete();
    cap_blk.delete();
    cap_last.delete();
  endtask

  function automatic bq_t seq(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'(i));
    return q;
  endfunction

  function automatic bq_t rnd(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  task automatic run_abc(input string tag);
    bq_t m;
    logic [511:0] want;
    m = '{8'h61, 8'h62, 8'h63};
    want = '0;
    want[511:480] = 32'h61626380;
    want[31:0]    = 32'h00000018;
    expect_msg(m);
    send(m, 1'b1, 0);
    chk({tag, "_load_n1"}, 512'(bus.load), 512'(0));
    tick();
    chk({tag, "_load_n2"}, 512'(bus.load), 512'(1));
    chk({tag, "_block"}, cur_blk(), want);
    chk({tag, "_last"}, 512'(bus.last_block), 512'(1));
    tick();
    chk({tag, "_load_drop"}, 512'(bus.load), 512'(0));
    drain(tag);
  endtask

  initial begin
    bq_t m;
    logic [511:0] snap;
    bus.in_valid    = 1'b0;
    bus.in_data     = 8'h00;
    bus.in_last     = 1'b0;
    bus.block_ready = 1'b1;
    #2;
    chk("rst_in_ready", 512'(bus.in_ready), 512'(0));
    chk("rst_load", 512'(bus.load), 512'(0));
    chk("rst_last", 512'(bus.last_block), 512'(0));
    chk("rst_message", cur_blk(), 512'(0));
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_in_ready", 512'(bus.in_ready), 512'(1));

    run_abc("s1");

    m = seq(55);
    expect_msg(m);
    send(m, 1'b1, 0);
    wait_blocks("s2");
    if (cap_blk.size() > 0) begin
      chk("s2_byte55", 512'(cap_blk[0][71:64]), 512'(8'h80));
      chk("s2_w15", 512'(cap_blk[0][31:0]), 512'(32'h1B8));
    end
    drain("s2");

    m = seq(56);
    expect_msg(m);
    send(m, 1'b1, 0);
    wait_blocks("s3");
    if (cap_blk.size() > 1) begin
      chk("s3_b1_tail", 512'(cap_blk[0][63:0]), 512'(64'h8000000000000000));
      chk("s3_b2_w15", 512'(cap_blk[1][31:0]), 512'(32'h1C0));
      chk("s3_b2_zero", 512'(cap_blk[1][511:32]), 512'(0));
    end
    drain("s3");

    m = rnd(64);
    expect_msg(m);
    send(m, 1'b1, 0);
    wait_blocks("s4");
    if (cap_blk.size() > 1) begin
      chk("s4_b1_last", 512'(cap_last[0]), 512'(0));
      chk("s4_b2_w0", 512'(cap_blk[1][511:480]), 512'(32'h80000000));
      chk("s4_b2_w15", 512'(cap_blk[1][31:0]), 512'(32'h200));
    end
    drain("s4");

    br_mode = 2;
    bus.block_ready = 1'b0;
    m = rnd(70);
    expect_msg(m);
    send(m[0:63], 1'b0, 0);
    chk("s5_load", 512'(bus.load), 512'(1));
    chk("s5_in_ready", 512'(bus.in_ready), 512'(0));
    snap = cur_blk();
    bus.in_valid = 1'b1;
    bus.in_data  = m[64];
    bus.in_last  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("s5_hold_load%0d", i), 512'(bus.load), 512'(1));
      chk($sformatf("s5_hold_msg%0d", i), cur_blk(), snap);
      chk($sformatf("s5_hold_rdy%0d", i), 512'(bus.in_ready), 512'(0));
    end
    bus.block_ready = 1'b1;
    br_mode = 0;
    tick();
    chk("s5_load_drop", 512'(bus.load), 512'(0));
    send(m[64:69], 1'b1, 0);
    drain("s5");

    send(rnd(20), 1'b0, 0);
    rst_n = 1'b0;
    #2;
    chk("s6_rst_in_ready", 512'(bus.in_ready), 512'(0));
    chk("s6_rst_message", cur_blk(), 512'(0));
    tick();
    rst_n = 1'b1;
    tick();
    run_abc("s6");

    br_mode = 1;
    for (int k = 0; k < 6; k++) begin
      m = rnd($urandom_range(1, 130));
      expect_msg(m);
      send(m, 1'b1, 3);
    end
    drain("b2b");
    br_mode = 0;
    bus.block_ready = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
